// File: rtl/regs_mp.sv
// Multi-port integer register file with WB bypass, issue scoreboard,
// req/ack debug access and a sequential clear engine.
module regs_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD = 2,
    parameter int SP_IDX = 2,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0001_0000)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_we_i,
    input  logic [ADDR_W-1:0]        wb_waddr_i,
    input  logic [DATA_W-1:0]        wb_wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [NUM_REGS-1:0]      pend_o,
    input  logic                     clr_i,
    output logic                     busy_o,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_ack_o,
    output logic [DATA_W-1:0]        dbg_rdata_o
);

    typedef enum logic [1:0] {IDLE, DBG, ACK, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic                armed;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_reg;
    logic [NUM_REGS-1:0] pend_next;
    logic                wb_write;
    logic                dbg_blocked;
    logic                dbg_write;

    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (a == '0) return '0;
        if (wb_we_i && (a == wb_waddr_i)) return wb_wdata_i;
        if (int'(a) >= NUM_REGS) return '0;
        return regs[a];
    endfunction

    assign wb_write    = wb_we_i && (wb_waddr_i != '0);
    // A debug write racing a WB to the same register waits rather than being lost.
    assign dbg_blocked = dbg_we_i && wb_we_i && (wb_waddr_i == dbg_addr_i);
    assign dbg_write   = (state == DBG) && dbg_we_i && !dbg_blocked && (dbg_addr_i != '0);

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        assign rd_data_o[gi*DATA_W +: DATA_W] = read_val(rd_addr_i[gi*ADDR_W +: ADDR_W]);
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [ADDR_W-1:0] GA   = ADDR_W'(gi);
        localparam logic [DATA_W-1:0] INIT = (gi == SP_IDX) ? SP_INIT : '0;
        logic              wb_sel;
        logic              clr_sel;
        logic              dbg_sel;
        logic [DATA_W-1:0] q;

        assign wb_sel  = wb_write && (wb_waddr_i == GA);
        assign clr_sel = (state == CLEAR) && (idx == GA);
        assign dbg_sel = dbg_write && (dbg_addr_i == GA);

        // WB beats the clear engine beats debug; losers to the same address are dropped.
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                q <= INIT;
            end else if (wb_sel) begin
                q <= wb_wdata_i;
            end else if (clr_sel) begin
                q <= INIT;
            end else if (dbg_sel) begin
                q <= dbg_wdata_i;
            end
        end

        assign regs[gi] = q;
    end

    always_comb begin
        pend_next = pend_reg;
        if ((state == IDLE) && clr_i) begin
            pend_next = '0;
        end else begin
            if (wb_we_i && (int'(wb_waddr_i) < NUM_REGS)) pend_next[wb_waddr_i] = 1'b0;
            if (iss_valid_i && (int'(iss_addr_i) < NUM_REGS)) pend_next[iss_addr_i] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign pend_o = pend_reg;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            idx         <= FIRST_IDX;
            armed       <= 1'b1;
            busy_o      <= 1'b0;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            dbg_ack_o <= 1'b0;
            // A request left high after its ack must be seen low before re-arming.
            if (!dbg_req_i) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_i) begin
                        state  <= CLEAR;
                        idx    <= FIRST_IDX;
                        busy_o <= 1'b1;
                    end else if (dbg_req_i && armed) begin
                        state <= DBG;
                        armed <= 1'b0;
                    end
                end
                DBG: begin
                    if (!dbg_blocked) begin
                        if (!dbg_we_i) dbg_rdata_o <= read_val(dbg_addr_i);
                        dbg_ack_o <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state  <= IDLE;
                        idx    <= FIRST_IDX;
                        busy_o <= 1'b0;
                    end else begin
                        idx <= idx + FIRST_IDX;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the register file.
module tb_regs_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD = 2;
    localparam int SP_IDX = 2;
    localparam logic [31:0] SP_INIT = 32'h0001_0000;

    logic                     clk;
    logic                     rst_n;
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_waddr;
    logic [DATA_W-1:0]        wb_wdata;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_REGS-1:0]      pend;
    logic                     clr;
    logic                     busy;
    logic                     dbg_req;
    logic                     dbg_we;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_wdata;
    logic                     dbg_ack;
    logic [DATA_W-1:0]        dbg_rdata;

    regs_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .NUM_RD(NUM_RD), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .pend_o(pend),
        .clr_i(clr), .busy_o(busy),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural contents, pending set, sweep position and debug progress.
    logic [31:0] m_regs [NUM_REGS];
    logic [31:0] m_pend;
    logic [31:0] m_rdata;
    int          m_sweep;
    bit          m_dbg_active;
    bit          m_ack;
    bit          m_armed;

    function automatic logic [31:0] init_val(input int a);
        return (a == SP_IDX) ? SP_INIT : 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (wb_we && (int'(wb_waddr) == a)) return wb_wdata;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = init_val(i);
        m_pend = 0; m_rdata = 0; m_sweep = 0;
        m_dbg_active = 0; m_ack = 0; m_armed = 1;
    endtask

    task automatic model_edge();
        logic [31:0] nregs [NUM_REGS];
        int wa;
        bit wbh, was_idle, start_sweep, ack_next;
        for (int i = 0; i < NUM_REGS; i++) nregs[i] = m_regs[i];
        wa = int'(wb_waddr);
        wbh = wb_we && (wa != 0);
        was_idle = (m_sweep == 0) && !m_dbg_active && !m_ack;
        start_sweep = 0;
        ack_next = 0;
        if (m_sweep != 0) begin
            if (!(wbh && wa == m_sweep)) nregs[m_sweep] = init_val(m_sweep);
            m_sweep = (m_sweep == NUM_REGS - 1) ? 0 : m_sweep + 1;
        end else if (m_dbg_active) begin
            if (!(dbg_we && wb_we && wb_waddr == dbg_addr)) begin
                if (dbg_we) begin
                    if (dbg_addr != 0) nregs[dbg_addr] = dbg_wdata;
                end else begin
                    m_rdata = m_read(int'(dbg_addr));
                end
                m_dbg_active = 0;
                ack_next = 1;
            end
        end
        if (!dbg_req) m_armed = 1;
        if (was_idle) begin
            if (clr) begin
                m_sweep = 1;
                start_sweep = 1;
            end else if (dbg_req && m_armed) begin
                m_dbg_active = 1;
                m_armed = 0;
            end
        end
        if (wbh) nregs[wa] = wb_wdata;
        if (start_sweep) begin
            m_pend = 0;
        end else begin
            if (wb_we) m_pend[wa] = 1'b0;
            if (iss_valid) m_pend[iss_addr] = 1'b1;
        end
        m_pend[0] = 1'b0;
        m_ack = ack_next;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = nregs[i];
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NUM_RD; k++)
            check_val($sformatf("rd%0d_a%0d", k, rd_addr[k*ADDR_W +: ADDR_W]),
                      rd_data[k*DATA_W +: DATA_W], m_read(int'(rd_addr[k*ADDR_W +: ADDR_W])));
        @(posedge clk);
        model_edge();
        #1;
        check_val("pend", pend, m_pend);
        check_val("busy", busy, m_sweep != 0);
        check_val("ack", dbg_ack, m_ack);
        check_val("dbg_rdata", dbg_rdata, m_rdata);
    endtask

    task automatic dbg_access(input bit we, input int addr, input logic [31:0] data,
                              input int block_n, output int lat);
        bit got;
        dbg_req = 1; dbg_we = we; dbg_addr = ADDR_W'(addr); dbg_wdata = data;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i >= 1 && i <= block_n) begin
                wb_we = 1; wb_waddr = ADDR_W'(addr); wb_wdata = $urandom;
            end else begin
                wb_we = 0;
            end
            step();
            lat++;
            if (dbg_ack === 1'b1) got = 1;
        end
        wb_we = 0;
        check_val("dbg_ack_seen", got, 1);
        dbg_req = 0;
        step();
    endtask

    task automatic read_all(input string tag, input logic [31:0] r31);
        for (int a = 0; a < NUM_REGS; a++) begin
            rd_addr[ADDR_W-1:0] = ADDR_W'(a);
            #1;
            check_val($sformatf("%s_r%0d", tag, a), rd_data[DATA_W-1:0],
                      (a == SP_IDX) ? SP_INIT : (a == NUM_REGS - 1) ? r31 : 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, cnt;
        bit drop_next;
        rst_n = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0; rd_addr = 0;
        iss_valid = 0; iss_addr = 0; clr = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

        // Reset asserted mid-clock.
        #12 rst_n = 1;
        model_reset();
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_pend", pend, 0);
        check_val("rst_ack", dbg_ack, 0);
        check_val("rst_rdata", dbg_rdata, 0);
        @(negedge clk) rst_n = 0;
        @(posedge clk); #1;
        read_all("rst", 32'h0);

        // Bypass.
        wb_we = 0; wb_waddr = 5; wb_wdata = 32'h1111_1111; rd_addr = {5'd5, 5'd0};
        #1 check_val("stale_no_bypass", rd_data[2*DATA_W-1:DATA_W], 32'h0);
        step();
        wb_we = 1; wb_wdata = 32'hDEAD_BEEF;
        #1 check_val("bypass_p1", rd_data[2*DATA_W-1:DATA_W], 32'hDEAD_BEEF);
        step();
        wb_we = 0; wb_wdata = 32'h2222_2222;
        #1 check_val("after_wb_p1", rd_data[2*DATA_W-1:DATA_W], 32'hDEAD_BEEF);
        step();
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF_FFFF; rd_addr = {5'd0, 5'd0};
        #1 check_val("r0_bypass", rd_data[DATA_W-1:0], 32'h0);
        step();
        wb_we = 0;
        #1 check_val("r0_after", rd_data[2*DATA_W-1:DATA_W], 32'h0);
        step();

        // Scoreboard.
        iss_valid = 1; iss_addr = 7;
        step();
        check_val("pend7_set", pend[7], 1);
        wb_we = 1; wb_waddr = 7; wb_wdata = 32'h77;
        step();
        check_val("pend7_setwins", pend[7], 1);
        iss_valid = 0;
        step();
        check_val("pend7_clr", pend[7], 0);
        wb_we = 0;

        // Debug access.
        dbg_access(1, 9, 32'h1234_5678, 0, lat);
        check_val("dbg_wr_lat", lat, 2);
        dbg_access(0, 9, 32'h0, 0, lat);
        check_val("dbg_rd_lat", lat, 2);
        check_val("dbg_rd_data", dbg_rdata, 32'h1234_5678);
        dbg_access(1, 9, 32'hABCD_0009, 3, lat);
        check_val("dbg_blk_lat", lat, 5);
        rd_addr = {5'd0, 5'd9};
        #1 check_val("dbg_blk_r9", rd_data[DATA_W-1:0], 32'hABCD_0009);
        dbg_access(0, 0, 32'h0, 0, lat);
        check_val("dbg_rd0", dbg_rdata, 32'h0);

        // Clear sweep with a WB racing the last slot.
        for (int a = 1; a < NUM_REGS; a++) begin
            wb_we = 1; wb_waddr = ADDR_W'(a); wb_wdata = $urandom | 32'h1;
            step();
        end
        wb_we = 0; iss_valid = 1; iss_addr = 12;
        step();
        iss_valid = 0;
        check_val("pend12_pre", pend[12], 1);
        clr = 1;
        step();
        clr = 0;
        cnt = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100 && busy === 1'b1; i++) begin
            if (m_sweep == NUM_REGS - 1) begin
                wb_we = 1; wb_waddr = 31; wb_wdata = 32'hCAFE_F00D;
            end else begin
                wb_we = 0;
            end
            step();
            if (busy === 1'b1) cnt++;
        end
        wb_we = 0;
        check_val("busy_cycles", cnt, NUM_REGS - 1);
        check_val("clr_pend", pend, 0);
        read_all("clr", 32'hCAFE_F00D);

        // Reset in the middle of a sweep.
        for (int a = 11; a < 16; a++) begin
            wb_we = 1; wb_waddr = ADDR_W'(a); wb_wdata = 32'h5A00_0000 | a;
            step();
        end
        wb_we = 0; clr = 1;
        step();
        clr = 0;
        for (int i = 0; i < 40 && m_sweep != 10; i++) step();
        check_val("sweep_at10", busy, 1);
        #2 rst_n = 1;
        model_reset();
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_ack", dbg_ack, 0);
        check_val("midrst_pend", pend, 0);
        @(negedge clk) rst_n = 0;
        @(posedge clk); #1;
        read_all("midrst", 32'h0);

        // Randomized traffic.
        drop_next = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wb_we = $urandom_range(0, 1);
            wb_waddr = ($urandom_range(0, 3) == 0) ? dbg_addr : ADDR_W'($urandom_range(0, 31));
            wb_wdata = $urandom;
            for (int k = 0; k < NUM_RD; k++)
                rd_addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? wb_waddr
                                              : ADDR_W'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_addr = ADDR_W'($urandom_range(0, 31));
            clr = ($urandom_range(0, 199) == 0);
            if (drop_next) begin
                dbg_req = 0; drop_next = 0;
            end else if (dbg_req && dbg_ack) begin
                if ($urandom_range(0, 3) == 0) drop_next = 1;
                else dbg_req = 0;
            end else if (!dbg_req && $urandom_range(0, 5) == 0) begin
                dbg_req = 1; dbg_we = $urandom_range(0, 1);
                dbg_addr = ADDR_W'($urandom_range(0, 31)); dbg_wdata = $urandom;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
